fetch_sequencer: RTL



---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core's fetch path.
//   CPU_ADDR_W / CPU_INSTR_W : default address and instruction widths
//   CPU_RESET_PC             : default PC after reset
//   fetch_state_t            : fetch sequencer state encoding (2 bits)
package cpu_pkg;

    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;

    localparam logic [15:0] CPU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch stage of the single-cycle core. Owns the architectural PC, issues
// instruction-memory reads at pc, holds the fetched instruction for the
// execute logic until commit, then loads the next PC. Stops for good on HLT.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_FETCH  | request outstanding at pc; capture rdata when imem_ready=1
// ST_EXEC   | instruction held in instr; wait for commit
// ST_HALTED | HLT committed; no further requests until reset
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   imem_req / imem_addr  read request and address (address is always pc)
//   imem_ready/imem_rdata memory handshake; rdata valid with ready
//   instr / instr_valid   held instruction and its valid flag
//   pc                    address of the held/fetching instruction
//   next_pc               sequential/relative next PC from PC control
//   br_en / br_target     register-indirect branch override
//   commit / halt         execute finished; halt marks the held instr as HLT
//   halted                sequencer stopped
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = CPU_ADDR_W,
    parameter int                 INSTR_W  = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  next_pc,
    input  logic               br_en,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               commit,
    input  logic               halt,
    output logic               halted
);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic               valid_nxt;
    logic [ADDR_W-1:0]  target_sel;

    assign target_sel = br_en ? br_target : next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        imem_req  = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_nxt = imem_rdata;
                    valid_nxt = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    valid_nxt = 1'b0;
                    if (halt) begin
                        // pc stays on the HLT instruction for debug visibility
                        state_nxt = ST_HALTED;
                    end else begin
                        // instructions are halfword aligned; drop bit 0
                        pc_nxt    = {target_sel[ADDR_W-1:1], 1'b0};
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                valid_nxt = 1'b0;
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = ST_FETCH;
            end
        endcase
    end

    assign imem_addr = pc;
    assign halted    = (state == ST_HALTED);

endmodule
